// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave in front of a 32-bit OpenRAM RW port. All macro inputs are
// registered; an optional post-reset sweep zero-fills the array before bus traffic is accepted.
module sram_wb_bridge #(
   parameter int ADDR_WIDTH = 8,
   parameter bit INIT_ZERO  = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [31:0]           i_wb_adr,
   input  logic [31:0]           i_wb_dat,
   input  logic [3:0]            i_wb_sel,
   input  logic                  i_wb_we,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   output logic [31:0]           o_wb_rdt,
   output logic                  o_wb_ack,
   output logic                  o_init_done,
   output logic                  o_sram_csb0,
   output logic                  o_sram_web0,
   output logic [3:0]            o_sram_wmask0,
   output logic [ADDR_WIDTH-1:0] o_sram_addr0,
   output logic [31:0]           o_sram_din0,
   input  logic [31:0]           i_sram_dout0
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_CAPTURE, S_ACK} state_t;
   localparam state_t RST_STATE = INIT_ZERO ? S_INIT : S_IDLE;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  csb_q, csb_d;
   logic                  web_q, web_d;
   logic [3:0]            wmask_q, wmask_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           din_q, din_d;
   logic [31:0]           rdt_q, rdt_d;
   logic                  ack_q, ack_d;
   logic                  done_q, done_d;
   logic                  we_q, we_d;
   logic                  req;
   logic                  unused_adr;

   assign req        = i_wb_cyc & i_wb_stb;
   assign unused_adr = ^{i_wb_adr[31:ADDR_WIDTH+2], i_wb_adr[1:0]};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         csb_q   <= 1'b1;
         web_q   <= 1'b1;
         wmask_q <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         rdt_q   <= '0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         csb_q   <= csb_d;
         web_q   <= web_d;
         wmask_q <= wmask_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rdt_q   <= rdt_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:    if (cnt_q[ADDR_WIDTH]) state_d = S_IDLE;
         S_IDLE:    if (done_q && req) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_ACK;
         S_ACK:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      csb_d   = csb_q;
      web_d   = web_q;
      wmask_d = wmask_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdt_d   = rdt_q;
      ack_d   = 1'b0;
      done_d  = done_q;
      we_d    = we_q;
      case (state_q)
         S_INIT: begin
            // cnt_q counts words already issued; its top bit marks the sweep as complete
            if (cnt_q[ADDR_WIDTH]) begin
               csb_d   = 1'b1;
               web_d   = 1'b1;
               wmask_d = '0;
               done_d  = 1'b1;
            end else begin
               csb_d   = 1'b0;
               web_d   = 1'b0;
               wmask_d = 4'hF;
               din_d   = '0;
               addr_d  = cnt_q[ADDR_WIDTH-1:0];
               cnt_d   = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (!done_q) begin
               done_d = 1'b1;
            end else if (req) begin
               csb_d   = 1'b0;
               web_d   = ~i_wb_we;
               wmask_d = i_wb_we ? i_wb_sel : 4'h0;
               addr_d  = i_wb_adr[ADDR_WIDTH+1:2];
               din_d   = i_wb_dat;
               we_d    = i_wb_we;
            end
         end
         S_ISSUE: begin
            csb_d = 1'b1;
            web_d = 1'b1;
         end
         S_CAPTURE: begin
            // macro output settles after its negedge access; sample only at the end of this cycle
            if (!we_q) rdt_d = i_sram_dout0;
            ack_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_wb_rdt      = rdt_q;
   assign o_wb_ack      = ack_q;
   assign o_init_done   = done_q;
   assign o_sram_csb0   = csb_q;
   assign o_sram_web0   = web_q;
   assign o_sram_wmask0 = wmask_q;
   assign o_sram_addr0  = addr_q;
   assign o_sram_din0   = din_q;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Bench for sram_wb_bridge: behavioural OpenRAM port model, word-array reference,
// directed scenarios followed by randomized bus traffic.
module tb_sram_wb_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] wb_adr = '0, wb_dat = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack, o_init_done, o_sram_csb0, o_sram_web0;
   logic [3:0]  o_sram_wmask0;
   logic [7:0]  o_sram_addr0;
   logic [31:0] o_sram_din0;
   logic [31:0] sram_dout = '0;

   int vectors = 0;
   int miscompares = 0;
   int cyc_cnt = 0;
   int n_samp = 0;
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];

   sram_wb_bridge dut (
      .i_clk(clk), .i_rst(rst),
      .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
      .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
      .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_init_done(o_init_done),
      .o_sram_csb0(o_sram_csb0), .o_sram_web0(o_sram_web0), .o_sram_wmask0(o_sram_wmask0),
      .o_sram_addr0(o_sram_addr0), .o_sram_din0(o_sram_din0), .i_sram_dout0(sram_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt++;

   // Macro port 0: samples at posedge, read data X until negedge plus delay
   initial begin
      logic [7:0] ra;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      forever begin
         @(posedge clk);
         if (!o_sram_csb0) begin
            n_samp++;
            if (!o_sram_web0) begin
               for (int b = 0; b < 4; b++)
                  if (o_sram_wmask0[b]) mem[o_sram_addr0][8*b +: 8] = o_sram_din0[8*b +: 8];
            end else begin
               ra = o_sram_addr0;
               sram_dout = 'x;
               @(negedge clk);
               #2 sram_dout = mem[ra];
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_csb"},   32'(o_sram_csb0), 32'd1);
      chk({tag, "_web"},   32'(o_sram_web0), 32'd1);
      chk({tag, "_wmask"}, 32'(o_sram_wmask0), 32'd0);
      chk({tag, "_addr"},  32'(o_sram_addr0), 32'd0);
      chk({tag, "_din"},   o_sram_din0, 32'd0);
      chk({tag, "_ack"},   32'(o_wb_ack), 32'd0);
      chk({tag, "_rdt"},   o_wb_rdt, 32'd0);
      chk({tag, "_done"},  32'(o_init_done), 32'd0);
   endtask

   task automatic ref_clear;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
   endtask

   task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel, input bit hold,
                       output int ack_cyc);
      int s0, lat;
      logic [31:0] rdata;
      s0 = n_samp;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
      lat = 0;
      do begin
         tick;
         lat++;
      end while (!o_wb_ack && lat < 20);
      rdata = o_wb_rdt;
      ack_cyc = cyc_cnt;
      chk({tag, "_lat"}, 32'(lat), 32'd3);
      chk({tag, "_csb_samples"}, 32'(n_samp - s0), 32'd1);
      if (!we) chk({tag, "_rdt"}, rdata, ref_mem[adr[9:2]]);
      if (we)
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
      if (!hold) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
      tick;
      chk({tag, "_ack_single"}, 32'(o_wb_ack), 32'd0);
   endtask

   initial begin
      int n, acks, a0, a1, nz;
      logic        rw;
      logic [31:0] ra, rd;

      // Reset, start fill, then async reset mid-cycle
      repeat (2) tick;
      rst = 1'b0;
      repeat (20) tick;
      chk("fill_csb_low", 32'(o_sram_csb0), 32'd0);
      #3 rst = 1'b1;
      #1 chk_reset("async_rst");
      tick;
      chk_reset("rst_held");

      // Fill timing with a read request raised during the sweep
      rst = 1'b0;
      n = 0; acks = 0;
      do begin
         tick;
         n++;
         if (n == 10) begin
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h004; wb_sel = 4'hF;
         end
         if (o_wb_ack) acks++;
      end while (!o_init_done && n < 400);
      chk("init_done_cycles", 32'(n), 32'd257);
      chk("init_no_ack", 32'(acks), 32'd0);
      n = 0;
      do begin
         tick;
         n++;
      end while (!o_wb_ack && n < 20);
      chk("init_req_lat", 32'(n), 32'd3);
      chk("init_req_rdt", o_wb_rdt, 32'd0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      tick;
      ref_clear();
      nz = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 32'd0) nz++;
      chk("fill_zero_words", 32'(nz), 32'd0);

      xfer("rd_3fc", 1'b0, 32'h3FC, 32'h0, 4'hF, 1'b0, a0);
      xfer("wr_full", 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 1'b0, a0);
      xfer("rd_full", 1'b0, 32'h010, 32'h0, 4'hF, 1'b0, a0);
      chk("rd_full_val", o_wb_rdt, 32'hDEADBEEF);
      xfer("wr_byte", 1'b1, 32'h010, 32'h0000AA00, 4'h2, 1'b0, a0);
      xfer("rd_byte", 1'b0, 32'h010, 32'h0, 4'h0, 1'b0, a0);
      chk("rd_byte_val", o_wb_rdt, 32'hDEADAAEF);
      xfer("wr_sel0", 1'b1, 32'h010, 32'hFFFFFFFF, 4'h0, 1'b0, a0);
      xfer("rd_sel0", 1'b0, 32'h010, 32'h0, 4'hF, 1'b0, a0);

      // Back-to-back with stb held, last word and word 0
      xfer("b2b_wr_last", 1'b1, 32'h3FC, 32'h12345678, 4'hF, 1'b1, a0);
      xfer("b2b_wr_zero", 1'b1, 32'h000, 32'hCAFEF00D, 4'hF, 1'b1, a1);
      chk("b2b_spacing", 32'(a1 - a0), 32'd4);
      xfer("b2b_rd_last", 1'b0, 32'h3FC, 32'h0, 4'hF, 1'b1, a0);
      xfer("b2b_rd_zero", 1'b0, 32'h000, 32'h0, 4'hF, 1'b0, a1);
      chk("b2b_rd_spacing", 32'(a1 - a0), 32'd4);
      xfer("rd_alias_400", 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, a0);
      chk("alias_400_val", o_wb_rdt, 32'hCAFEF00D);

      // Reset while the read is in CAPTURE
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h3FC; wb_sel = 4'hF;
      tick;
      tick;
      #3 rst = 1'b1;
      #1 chk_reset("rst_capture");
      tick;
      chk("rst_capture_no_ack", 32'(o_wb_ack), 32'd0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      rst = 1'b0;
      tick;
      chk("refill_csb", 32'(o_sram_csb0), 32'd0);
      chk("refill_web", 32'(o_sram_web0), 32'd0);
      chk("refill_addr0", 32'(o_sram_addr0), 32'd0);
      chk("refill_wmask", 32'(o_sram_wmask0), 32'hF);
      tick;
      chk("refill_addr1", 32'(o_sram_addr0), 32'd1);
      n = 2;
      while (!o_init_done && n < 400) begin tick; n++; end
      chk("refill_done_cycles", 32'(n), 32'd257);
      ref_clear();
      xfer("rd_after_refill", 1'b0, 32'h3FC, 32'h0, 4'hF, 1'b0, a0);

      // Randomized traffic, clustered on a few words to get read hits
      for (int k = 0; k < 48; k++) begin
         repeat ($urandom_range(0, 2)) tick;
         rw = 1'($urandom_range(0, 1));
         ra = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
         rd = $urandom;
         xfer("rand", rw, ra, rd, 4'($urandom_range(0, 15)), 1'b0, a0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
